dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width for both ports and memory.
REQ-002 Parameter ADDR_W, default 32, byte address width; addresses are word-aligned and passed through unchanged.
REQ-003 Parameter MAX_BURST, default 8, max consecutive locked coprocessor grants while the CPU is waiting.
REQ-004 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0.
REQ-006 cpu_req, cpu_we  input  1 each  CPU access request and write enable.
REQ-007 cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W  CPU request payload.
REQ-008 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-009 cpu_rvalid  output  1; cpu_rdata  output  DATA_W  CPU read return.
REQ-010 cop_req, cop_we, cop_lock  input  1 each  coprocessor request, write enable, burst-lock hint.
REQ-011 cop_addr  input  ADDR_W; cop_wdata  input  DATA_W  coprocessor payload.
REQ-012 cop_gnt  output  1; cop_rvalid  output  1; cop_rdata  output  DATA_W  coprocessor grant and read return.
REQ-013 mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  single-port memory command.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en&&!mem_we.
REQ-015 conflict_cnt  output  16  saturating count of cycles in which both ports requested.

Function
REQ-016 At most one of cpu_gnt/cop_gnt SHALL be high in any cycle; gnt is combinational from req and registered arbitration state.
REQ-017 In a granted cycle mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal the winner's payload; otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-018 Requesters SHALL hold req and payload stable until gnt; deasserting req before gnt is legal and drops the request.
REQ-019 Single requester SHALL be granted in the same cycle (zero arbitration latency).
REQ-020 Both requesting, no active lock: winner SHALL be the port not granted last (last_owner register, round-robin).
REQ-021 Lock state: burst_cnt (width clog2(MAX_BURST+1)) SHALL increment on each cop grant with cop_lock=1 and clear on any cpu grant, any cop grant with cop_lock=0, or any cycle with cop_req=0.
REQ-022 Both requesting with cop_lock=1, last_owner=COP and burst_cnt<MAX_BURST: cop SHALL win; at burst_cnt==MAX_BURST cpu SHALL win.
REQ-023 CPU wait while requesting SHALL never exceed MAX_BURST cycles.
REQ-024 Read latency SHALL be one cycle: a read granted in cycle N produces <port>_rvalid=1 and <port>_rdata=mem_rdata in cycle N+1, routed by a registered owner tag.
REQ-025 Non-returning port's rdata SHALL be 0; rvalid is a single-cycle pulse; writes produce no rvalid.
REQ-026 Back-to-back reads from alternating ports SHALL each return to the correct port with no bubble.
REQ-027 conflict_cnt SHALL increment when cpu_req&&cop_req and saturate at 16'hFFFF.
REQ-028 last_owner SHALL update only on a grant; idle cycles preserve it.

Reset
REQ-029 While rst==0 at a clk edge: last_owner=COP (CPU wins first tie), burst_cnt=0, conflict_cnt=0, owner tag cleared, rvalid regs=0.
REQ-030 During and after reset, cpu_rvalid=0, cop_rvalid=0, rdata=0; gnt and mem_en SHALL be 0 while rst==0.
REQ-031 A read granted in the cycle reset asserts SHALL produce no rvalid after reset.

Verification
REQ-032 Solo CPU: sw 15 to addr 0 then lw addr 0 -> cpu_gnt same cycle each, cpu_rvalid=1 one cycle later with cpu_rdata=15, cop_rvalid=0.
REQ-033 First tie after reset: both req reads addr 0x4/0x8 -> cycle0 cpu_gnt, cycle1 cop_gnt, rvalids return in order, conflict_cnt=1.
REQ-034 Locked burst, MAX_BURST=8: cop_req+cop_lock held 12 cycles, cpu_req from cycle 0 -> cpu first tie, then cop granted 8 cycles, then cpu_gnt; CPU max wait 8.
REQ-035 Unlocked contention 6 cycles -> grants alternate cpu,cop,cpu,cop,cpu,cop; conflict_cnt=6.
REQ-036 Reset mid-read: cop read granted, rst=0 next edge -> cop_rvalid stays 0, conflict_cnt=0, burst_cnt=0.
REQ-037 Saturation: force 65540 contention cycles -> conflict_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (cpu/coprocessor) arbiter onto a single-port data memory
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cop_req,
    input  logic              cop_we,
    input  logic              cop_lock,
    input  logic [ADDR_W-1:0] cop_addr,
    input  logic [DATA_W-1:0] cop_wdata,
    output logic              cop_gnt,
    output logic              cop_rvalid,
    output logic [DATA_W-1:0] cop_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {OWN_CPU, OWN_COP} owner_t;
    owner_t          last_owner;
    logic [BW-1:0]   burst_cnt;
    logic            rv_cpu;
    logic            rv_cop;
    logic            cop_hold;
    // grant selection, memory command mux and read-return routing
    always_comb begin
        cop_hold   = cop_lock && burst_cnt != '0 && burst_cnt < BW'(MAX_BURST);
        cop_gnt    = rst && cop_req && (!cpu_req || last_owner == OWN_CPU || cop_hold);
        cpu_gnt    = rst && cpu_req && !cop_gnt;
        mem_en     = cpu_gnt || cop_gnt;
        mem_we     = cpu_gnt ? cpu_we : cop_gnt && cop_we;
        mem_addr   = cpu_gnt ? cpu_addr : cop_gnt ? cop_addr : '0;
        mem_wdata  = cpu_gnt ? cpu_wdata : cop_gnt ? cop_wdata : '0;
        cpu_rvalid = rst && rv_cpu;
        cop_rvalid = rst && rv_cop;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        cop_rdata  = cop_rvalid ? mem_rdata : '0;
    end
    // arbitration history, lock burst length, conflict counter and read owner tags
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner   <= OWN_COP;
            burst_cnt    <= '0;
            conflict_cnt <= '0;
            rv_cpu       <= 1'b0;
            rv_cop       <= 1'b0;
        end else begin
            if (mem_en)
                last_owner <= cop_gnt ? OWN_COP : OWN_CPU;
            burst_cnt <= (cop_gnt && cop_lock) ?
                         (burst_cnt == BW'(MAX_BURST) ? burst_cnt : burst_cnt + BW'(1)) : '0;
            if (cpu_req && cop_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
            rv_cpu <= cpu_gnt && !cpu_we;
            rv_cop <= cop_gnt && !cop_we;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus, behavioural model and memory stub for dmem_arbiter
module tb_dmem_arbiter;
    localparam int MAXB = 8;
    logic        clk = 0;
    logic        rst = 0;
    logic        cpu_req = 0, cpu_we = 0, cop_req = 0, cop_we = 0, cop_lock = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cop_addr = 0, cop_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, cop_gnt, cop_rvalid, mem_en, mem_we;
    logic [31:0] cpu_rdata, cop_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] stub_mem [256];
    logic [31:0] m_mem [256];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cop_req(cop_req), .cop_we(cop_we), .cop_lock(cop_lock), .cop_addr(cop_addr),
        .cop_wdata(cop_wdata), .cop_gnt(cop_gnt), .cop_rvalid(cop_rvalid), .cop_rdata(cop_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // single-port memory stub: registered read data, write on granted writes
    initial begin
        for (int i = 0; i < 256; i++) stub_mem[i] = 32'hA000 + i;
        forever begin
            @(posedge clk);
            mem_rdata <= stub_mem[mem_addr[9:2]];
            if (mem_en && mem_we) stub_mem[mem_addr[9:2]] = mem_wdata;
        end
    end

    // behavioural model: decides the winner from the arbitration rules and checks every cycle
    initial begin
        logic        m_last_cop, e_cpu, e_cop, e_we;
        logic [31:0] e_addr, e_wd, m_data;
        int          m_streak, m_conf, m_ret, wait_cyc;
        m_last_cop = 1; m_streak = 0; m_conf = 0; m_ret = 0; m_data = 0; wait_cyc = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'hA000 + i;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
                chk("rst_cop_gnt", 32'(cop_gnt), 0);
                chk("rst_mem_en", 32'(mem_en), 0);
                chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
                chk("rst_cop_rvalid", 32'(cop_rvalid), 0);
                chk("rst_cop_rdata", cop_rdata, 0);
                m_last_cop = 1; m_streak = 0; m_conf = 0; m_ret = 0; wait_cyc = 0;
            end else begin
                e_cop  = cop_req && (!cpu_req || !m_last_cop ||
                         (cop_lock && m_streak > 0 && m_streak < MAXB));
                e_cpu  = cpu_req && !e_cop;
                e_we   = e_cpu ? cpu_we : (e_cop && cop_we);
                e_addr = e_cpu ? cpu_addr : e_cop ? cop_addr : 0;
                e_wd   = e_cpu ? cpu_wdata : e_cop ? cop_wdata : 0;
                chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
                chk("cop_gnt", 32'(cop_gnt), 32'(e_cop));
                chk("mem_en", 32'(mem_en), 32'(e_cpu || e_cop));
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wd);
                chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_ret == 1));
                chk("cpu_rdata", cpu_rdata, m_ret == 1 ? m_data : 0);
                chk("cop_rvalid", 32'(cop_rvalid), 32'(m_ret == 2));
                chk("cop_rdata", cop_rdata, m_ret == 2 ? m_data : 0);
                chk("conflict_cnt", 32'(conflict_cnt), m_conf);
                if (cpu_req) begin
                    if (cpu_gnt) begin
                        chk("cpu_wait_bound", 32'(wait_cyc <= MAXB), 1);
                        wait_cyc = 0;
                    end else wait_cyc++;
                end else wait_cyc = 0;
                m_ret  = (e_cpu || e_cop) && !e_we ? (e_cpu ? 1 : 2) : 0;
                m_data = m_mem[e_addr[9:2]];
                if ((e_cpu || e_cop) && e_we) m_mem[e_addr[9:2]] = e_wd;
                if (e_cpu || e_cop) m_last_cop = e_cop;
                m_streak = (e_cop && cop_lock) ? (m_streak < MAXB ? m_streak + 1 : MAXB) : 0;
                if (cpu_req && cop_req && m_conf < 65535) m_conf++;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        cyc;
        rst = 0; cpu_req = 0; cop_req = 0; cop_lock = 0;
        cyc;
        rst = 1;
    endtask

    // directed scenarios with hand-computed expectations
    initial begin
        logic [11:0] pc, po;
        cyc; cyc;
        rst = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4; cop_req = 1; cop_we = 0; cop_addr = 32'h8;
        @(negedge clk); chk("tie0_cpu_gnt", 32'(cpu_gnt), 1); chk("tie0_cop_gnt", 32'(cop_gnt), 0);
        cyc; cpu_req = 0;
        @(negedge clk); chk("tie1_cop_gnt", 32'(cop_gnt), 1); chk("tie1_cpu_rdata", cpu_rdata, 32'hA001);
        cyc; cop_req = 0;
        @(negedge clk); chk("tie2_cop_rdata", cop_rdata, 32'hA002); chk("tie_conflict", 32'(conflict_cnt), 1);
        cyc; cpu_req = 1; cpu_we = 1; cpu_addr = 0; cpu_wdata = 15;
        @(negedge clk); chk("sw_gnt", 32'(cpu_gnt), 1);
        cyc; cpu_we = 0;
        @(negedge clk); chk("lw_gnt", 32'(cpu_gnt), 1);
        cyc; cpu_req = 0;
        @(negedge clk); chk("lw_rvalid", 32'(cpu_rvalid), 1); chk("lw_rdata", cpu_rdata, 15);
        chk("lw_cop_rvalid", 32'(cop_rvalid), 0);
        do_reset;
        cpu_req = 1; cpu_addr = 32'h30; cop_req = 1; cop_we = 0; cop_addr = 32'h34;
        pc = 0; po = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); pc[i] = cpu_gnt; po[i] = cop_gnt;
            cyc;
        end
        cpu_req = 0; cop_req = 0;
        @(negedge clk);
        chk("rr_cpu_pattern", 32'(pc), 32'h15); chk("rr_cop_pattern", 32'(po), 32'h2A);
        chk("rr_conflict", 32'(conflict_cnt), 6);
        do_reset;
        cpu_req = 1; cpu_addr = 32'h10; cop_req = 1; cop_lock = 1; cop_we = 1; cop_addr = 32'h20;
        pc = 0; po = 0;
        for (int i = 0; i < 12; i++) begin
            cop_wdata = 32'h100 + i;
            @(negedge clk); pc[i] = cpu_gnt; po[i] = cop_gnt;
            cyc;
        end
        cpu_req = 0; cop_req = 0; cop_lock = 0; cop_we = 0;
        @(negedge clk);
        chk("lock_cpu_pattern", 32'(pc), 32'h201); chk("lock_cop_pattern", 32'(po), 32'hDFE);
        cyc; cop_req = 1; cop_addr = 32'hC;
        @(negedge clk); chk("rstrd_gnt", 32'(cop_gnt), 1);
        cyc; rst = 0; cop_req = 0;
        @(negedge clk); chk("rstrd_rvalid_in_rst", 32'(cop_rvalid), 0);
        cyc; rst = 1;
        @(negedge clk); chk("rstrd_rvalid_after", 32'(cop_rvalid), 0);
        chk("rstrd_conflict", 32'(conflict_cnt), 0);
        cyc; cpu_req = 1; cop_req = 1; cop_lock = 1; cpu_addr = 32'h40; cop_addr = 32'h44;
        @(negedge clk); chk("rstrd_burst_clear", 32'(cpu_gnt), 1);
        repeat (65540) cyc;
        cpu_req = 0; cop_req = 0; cop_lock = 0;
        @(negedge clk); chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
        cyc;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
